// File: rtl/flag_unit_if.sv
// Flag-unit port bundle: EX-stage condition/flag inputs and resolved flag outputs.
// The pipeline drives through 'master'; flag_unit receives through 'slave'.
interface flag_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             adv;
    logic             flush;
    logic             ex_valid;
    logic [1:0]       ex_cond;
    logic             ex_wr_c;
    logic             ex_wr_z;
    logic             ex_z_late;
    logic             ex_carry;
    logic [WIDTH-1:0] ex_result;
    logic [WIDTH-1:0] mem_rdata;
    logic             ex_exec;
    logic             carry_in;
    logic             flag_stall;
    logic             c_flag;
    logic             z_flag;

    modport master (
        output adv, flush, ex_valid, ex_cond, ex_wr_c, ex_wr_z, ex_z_late, ex_carry,
        output ex_result, mem_rdata,
        input  ex_exec, carry_in, flag_stall, c_flag, z_flag
    );

    modport slave (
        input  adv, flush, ex_valid, ex_cond, ex_wr_c, ex_wr_z, ex_z_late, ex_carry,
        input  ex_result, mem_rdata,
        output ex_exec, carry_in, flag_stall, c_flag, z_flag
    );
endinterface

// File: rtl/flag_unit.sv
// C/Z condition-code unit with MEM/WB pending flag writes and EX predication.
// Define FLAG_FWD_EN to forward pending flags; otherwise EX stalls on any pending writer.
module flag_unit (
    input  logic      clk,
    input  logic      rst_n,
    flag_unit_if.slave bus
);

    typedef enum logic [1:0] {
        CondAlways = 2'b00,
        CondC      = 2'b01,
        CondZ      = 2'b10,
        CondCarry  = 2'b11
    } cond_e;

    typedef struct packed {
        logic valid;
        logic wr_c;
        logic wr_z;
        logic c;
        logic z;
    } entry_t;

    entry_t p1_q, p1_d, p2_q, p2_d;
    logic   p1_z_late_q, p1_z_late_d;
    logic   c_q, c_d, z_q, z_d;

    logic   p1_wc, p1_wz, p2_wc, p2_wz;
    logic   p1_z_now;
    logic   eff_c, eff_z;
    logic   exec, stall, capture;
    cond_e  cond;

    assign cond  = cond_e'(bus.ex_cond);
    assign p1_wc = p1_q.valid & p1_q.wr_c;
    assign p1_wz = p1_q.valid & p1_q.wr_z;
    assign p2_wc = p2_q.valid & p2_q.wr_c;
    assign p2_wz = p2_q.valid & p2_q.wr_z;

    // A load's Z only exists while it sits in P1, taken from the returning data.
    assign p1_z_now = p1_z_late_q ? (bus.mem_rdata == '0) : p1_q.z;

`ifdef FLAG_FWD_EN
    assign eff_c = p1_wc ? p1_q.c : (p2_wc ? p2_q.c : c_q);
    assign eff_z = p1_wz ? p1_z_now : (p2_wz ? p2_q.z : z_q);
    assign stall = bus.ex_valid & (cond == CondZ) & p1_wz & p1_z_late_q;
`else
    logic reads_c, reads_z;
    assign eff_c   = c_q;
    assign eff_z   = z_q;
    assign reads_c = (cond == CondC) | (cond == CondCarry);
    assign reads_z = (cond == CondZ);
    assign stall   = bus.ex_valid & ((reads_c & (p1_wc | p2_wc)) | (reads_z & (p1_wz | p2_wz)));
`endif

    always_comb begin
        exec = 1'b0;
        if (bus.ex_valid) begin
            unique case (cond)
                CondC:   exec = eff_c;
                CondZ:   exec = eff_z;
                default: exec = 1'b1;
            endcase
        end
    end

    assign capture = bus.ex_valid & exec & ~stall & ~bus.flush & (bus.ex_wr_c | bus.ex_wr_z);

    always_comb begin
        p1_d        = '0;
        p1_z_late_d = 1'b0;
        if (capture) begin
            p1_d.valid  = 1'b1;
            p1_d.wr_c   = bus.ex_wr_c;
            p1_d.wr_z   = bus.ex_wr_z;
            p1_d.c      = bus.ex_carry;
            p1_d.z      = bus.ex_z_late ? 1'b0 : (bus.ex_result == '0);
            p1_z_late_d = bus.ex_z_late;
        end
        p2_d   = p1_q;
        p2_d.z = p1_z_now;
        c_d    = p2_wc ? p2_q.c : c_q;
        z_d    = p2_wz ? p2_q.z : z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q        <= '0;
            p1_z_late_q <= 1'b0;
            p2_q        <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
        end else if (bus.adv) begin
            p1_q        <= p1_d;
            p1_z_late_q <= p1_z_late_d;
            p2_q        <= p2_d;
            c_q         <= c_d;
            z_q         <= z_d;
        end
    end

    assign bus.ex_exec    = exec;
    assign bus.carry_in   = eff_c;
    assign bus.flag_stall = stall;
    assign bus.c_flag     = c_q;
    assign bus.z_flag     = z_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit; expected outputs are queued per cycle and a
// negedge monitor pops and compares them. Expectations follow FLAG_FWD_EN.
`timescale 1ns/1ps
module tb_flag_unit;

    localparam int unsigned W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flag_unit_if #(.WIDTH(W)) bus ();

    flag_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string tag;
        logic  exec;
        logic  stall;
        logic  cin;
        logic  c;
        logic  z;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input string fld, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %b expected %b", tag, fld, act, req);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "ex_exec",    bus.ex_exec,    e.exec);
                chk(e.tag, "flag_stall", bus.flag_stall, e.stall);
                chk(e.tag, "carry_in",   bus.carry_in,   e.cin);
                chk(e.tag, "c_flag",     bus.c_flag,     e.c);
                chk(e.tag, "z_flag",     bus.z_flag,     e.z);
            end
        end
    end

    // One pipeline cycle: drive inputs, queue the expected response, advance past the edge.
    task automatic step(input string tag, input logic rst, input logic adv, input logic fl,
                        input logic v, input logic [1:0] cond, input logic wc, input logic wz,
                        input logic zl, input logic car, input logic [15:0] res,
                        input logic [15:0] rd, input logic e_exec, input logic e_stall,
                        input logic e_cin, input logic e_c, input logic e_z);
        exp_t e;
        rst_n         = ~rst;
        bus.adv       = adv;
        bus.flush     = fl;
        bus.ex_valid  = v;
        bus.ex_cond   = cond;
        bus.ex_wr_c   = wc;
        bus.ex_wr_z   = wz;
        bus.ex_z_late = zl;
        bus.ex_carry  = car;
        bus.ex_result = res;
        bus.mem_rdata = rd;
        e.tag = tag; e.exec = e_exec; e.stall = e_stall; e.cin = e_cin; e.c = e_c; e.z = e_z;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic adv, input logic e_cin,
                        input logic e_c, input logic e_z);
        step(tag, 1'b0, adv, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222,
             1'b0, 1'b0, e_cin, e_c, e_z);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.adv = 1'b0; bus.flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_cond = 2'b00;
        bus.ex_wr_c = 1'b0; bus.ex_wr_z = 1'b0; bus.ex_z_late = 1'b0; bus.ex_carry = 1'b0;
        bus.ex_result = '0; bus.mem_rdata = '0;
        @(posedge clk);
        #1;

        // Reset state: only unconditional conds execute.
        step("rst_c00", 1, 1, 0, 1, 2'b00, 1, 1, 0, 1, 16'h0, 16'h0, 1, 0, 0, 0, 0);
        step("rst_c01", 1, 1, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        step("rst_c10", 1, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        step("rst_c11", 1, 1, 0, 1, 2'b11, 0, 0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0);

        // Commit latency: C=1, Z=1 visible only after the third edge.
        step("add_cz", 0, 1, 0, 1, 2'b00, 1, 1, 0, 1, 16'h0000, 16'h0, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        idle("lat_p1", 1, 1, 0, 0);
        idle("lat_p2", 1, 1, 0, 0);
`else
        idle("lat_p1", 1, 0, 0, 0);
        idle("lat_p2", 1, 0, 0, 0);
`endif
        idle("lat_arch", 1, 1, 1, 1);
        do_reset("rst_a");

        // Carry producer followed immediately by a C-conditional consumer.
        step("add_c", 0, 1, 0, 1, 2'b00, 1, 0, 0, 1, 16'h0005, 16'h0, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        step("adc_fwd", 0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 0, 0);
        idle("adc_p2", 1, 1, 0, 0);
        idle("adc_arch", 1, 1, 1, 0);
`else
        step("adc_st1", 0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0);
        step("adc_st2", 0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0);
        step("adc_go",  0, 1, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 1, 0);
`endif
        do_reset("rst_b");

        // Load-produced Z, data zero.
        step("ld0", 0, 1, 0, 1, 2'b00, 0, 1, 1, 0, 16'h1234, 16'h0, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        step("adz0_st", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0000, 1, 1, 0, 0, 0);
        step("adz0_go", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h5555, 1, 0, 0, 0, 0);
        idle("ld0_arch", 1, 0, 0, 1);
`else
        step("adz0_st1", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 1, 0, 0, 0);
        step("adz0_st2", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h5555, 0, 1, 0, 0, 0);
        step("adz0_go",  0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h5555, 1, 0, 0, 0, 1);
`endif
        do_reset("rst_c");

        // Load-produced Z, data nonzero: consumer is predicated off after the stall.
        step("ld1", 0, 1, 0, 1, 2'b00, 0, 1, 1, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        step("adz1_st", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0001, 0, 1, 0, 0, 0);
        step("adz1_go", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0, 0);
`else
        step("adz1_st1", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0001, 0, 1, 0, 0, 0);
        step("adz1_st2", 0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 1, 0, 0, 0);
        step("adz1_go",  0, 1, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0, 0);
`endif
        do_reset("rst_d");

        // Predicated-off writer leaves no trace.
        step("pred_off", 0, 1, 0, 1, 2'b01, 1, 1, 0, 1, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        idle("po_1", 1, 0, 0, 0);
        idle("po_2", 1, 0, 0, 0);
        idle("po_3", 1, 0, 0, 0);

        // Flushed writer leaves no trace.
        step("flush_wr", 0, 1, 1, 1, 2'b00, 1, 1, 0, 1, 16'h0, 16'h0, 1, 0, 0, 0, 0);
        idle("fl_1", 1, 0, 0, 0);
        idle("fl_2", 1, 0, 0, 0);
        idle("fl_3", 1, 0, 0, 0);

        // Two writers in flight, then freeze, then in-order commit.
        step("wr1", 0, 1, 0, 1, 2'b00, 1, 0, 0, 1, 16'h0001, 16'h0, 1, 0, 0, 0, 0);
`ifdef FLAG_FWD_EN
        step("wr2", 0, 1, 0, 1, 2'b00, 1, 1, 0, 0, 16'h0000, 16'h0, 1, 0, 1, 0, 0);
`else
        step("wr2", 0, 1, 0, 1, 2'b00, 1, 1, 0, 0, 16'h0000, 16'h0, 1, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            // A would-be writer in EX while frozen must not be captured.
            step("hold", 0, 0, 0, 1, 2'b00, 1, 1, 0, 1, 16'h0000, 16'h0, 1, 0, 0, 0, 0);
        end
        idle("go1", 1, 0, 0, 0);
`ifdef FLAG_FWD_EN
        idle("go2", 1, 0, 1, 0);
`else
        idle("go2", 1, 1, 1, 0);
`endif
        idle("go3", 1, 0, 0, 1);

        // Asynchronous reset with C=1 writes pending in P1 and P2.
        step("w1", 0, 1, 0, 1, 2'b00, 1, 0, 0, 1, 16'h0001, 16'h0, 1, 0, 0, 0, 1);
`ifdef FLAG_FWD_EN
        step("w2", 0, 1, 0, 1, 2'b00, 1, 0, 0, 1, 16'h0001, 16'h0, 1, 0, 1, 0, 1);
`else
        step("w2", 0, 1, 0, 1, 2'b00, 1, 0, 0, 1, 16'h0001, 16'h0, 1, 0, 0, 0, 1);
`endif
        step("rst_mid", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
        idle("post_1", 1, 0, 0, 0);
        idle("post_2", 1, 0, 0, 0);
        idle("post_3", 1, 0, 0, 0);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
